writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage; consumes the registered outputs of the memory read/write stage.
//  Owns the 32 x 64-bit architectural register file, with two decode read ports and same-cycle write bypass.
//  Issues the PC redirect for resolved branch/jump addresses and counts retired results.
//  Runs the end-of-program sequence: drain, then cache flush handshake, then halt.
// PARAMETERS
//  NUM_REGS   32   architectural registers; x0 is hardwired to zero
//  CNT_W      64   width of the retired-result counter
// PORTS
//  clk                   in   1      clock; all state updates on posedge
//  rst                   in   1      synchronous, active-high reset
//  mem_result_q          in   64     result from memory stage (double_word)
//  mem_result_q_plus_4   in   64     {result[63:1],0}+4 from memory stage
//  mem_result_valid_q    in   1      result valid this cycle
//  mem_is_branch_addr_q  in   1      result is a branch/jump target
//  mem_write_to_rd_q     in   1      result is to be written to rd
//  mem_rd_q              in   5      destination register index
//  mem_should_end_q      in   1      result is the program-ending instruction
//  rs1_addr, rs2_addr    in   5      decode read addresses
//  rs1_data, rs2_data    out  64     decode read data (combinational, bypassed)
//  redirect_valid        out  1      one-cycle PC redirect pulse
//  redirect_pc           out  64     redirect target, bit 0 cleared
//  redirect_pc_plus_4    out  64     sequential successor of target (fetch prefetch hint)
//  flush_req             out  1      cache flush request (level, held until done)
//  flush_done            in   1      cache flush complete (single-cycle pulse)
//  retired_count         out  CNT_W  number of accepted valid results
//  halted                out  1      program ended and cache flushed
// BEHAVIOUR
//  Reset: all registers = 0, redirect_valid = 0, flush_req = 0, retired_count = 0,
//    halted = 0, FSM = RUN. Reset mid-flush abandons the handshake and returns to RUN.
//  Accept: a result is accepted only when mem_result_valid_q = 1 and FSM = RUN.
//    Inputs are ignored in FLUSH and HALTED. The stage never stalls (no ready output).
//  Reg write: if accepted, mem_write_to_rd_q = 1, mem_is_branch_addr_q = 0 and rd != 0:
//    regs[rd] <= mem_result_q at the posedge. Writes to x0 are dropped.
//    A branch-addr result never writes rd; execute issues the link value as a separate non-branch result.
//  Read: rsN_data = 0 if rsN_addr = 0. Else, if a write to the same index is accepted
//    this cycle, rsN_data = mem_result_q (bypass). Else rsN_data = regs[rsN_addr].
//  Redirect: an accepted result with mem_is_branch_addr_q = 1 sets, next cycle:
//    redirect_valid = 1, redirect_pc = {mem_result_q[63:1],1'b0}, redirect_pc_plus_4 = mem_result_q_plus_4.
//    redirect_valid drops after exactly one cycle. The pc outputs hold their value until the next redirect.
//  Counter: retired_count += 1 per accepted result, wrapping modulo 2^CNT_W.
//  FSM:
//    RUN -> FLUSH on an accepted result with mem_should_end_q = 1. That result is still
//      written, redirected and counted.
//    FLUSH: flush_req = 1. FLUSH -> HALTED on flush_done = 1. flush_done seen in the same
//      cycle as entry into FLUSH is ignored.
//    HALTED: halted = 1 and flush_req = 0. HALTED is left only by rst.
//  Simultaneous events: branch + end-of-program in one result gives both the redirect pulse
//    and the move to FLUSH. A bypass read and a write to the same register in one cycle
//    return the new value.
// STRUCTURE
//  Shared package instruction_decode_types: double_word typedef, wb_state_e {WB_RUN, WB_FLUSH, WB_HALTED}.
//  One sub-module, reg_file_2r1w: NUM_REGS x 64, with x0 forcing and write bypass.
//  FSM, redirect register and counter stay in writeback_stage.
// TESTING
//  1. Reset, then valid write rd=5 data=0xDEAD_BEEF -> next cycle rs1_addr=5 reads 0xDEAD_BEEF; retired_count=1.
//  2. Write rd=0 data=0x1234 -> rs1_addr=0 reads 0; retired_count still increments.
//  3. Same-cycle write rd=7 data=0xAA with rs2_addr=7 -> rs2_data=0xAA in that cycle.
//  4. Branch result 0x8000_0003, plus_4=0x8000_0006, write_to_rd=1, rd=1 -> one-cycle redirect_valid;
//     redirect_pc=0x8000_0002, redirect_pc_plus_4=0x8000_0006; x1 unchanged.
//  5. End-of-program result -> flush_req=1 until flush_done; halted=1 the cycle after;
//     later valid writes ignored and retired_count frozen.
//  6. rst asserted while in FLUSH -> flush_req=0, halted=0, all registers 0, FSM=RUN next cycle.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: the 64-bit data word and the
// end-of-program sequencing states.
package instruction_decode_types;

  localparam int XLEN        = 64;
  localparam int REG_ADDR_W  = 5;

  typedef logic [XLEN-1:0] double_word;

  typedef enum logic [1:0] {
    WB_RUN    = 2'd0,
    WB_FLUSH  = 2'd1,
    WB_HALTED = 2'd2
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_reg_file.sv
// Architectural register file: NUM_REGS x 64, two combinational read ports,
// one write port. x0 always reads zero and ignores writes; a read of the
// index being written in the same cycle returns the incoming data.
module reg_file_2r1w
  import instruction_decode_types::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  double_word            wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output double_word            rdata1,
  output double_word            rdata2
);

  double_word regs_q [NUM_REGS];
  logic       wr_en;

  assign wr_en = we && (waddr != '0);

  // Register array update; synchronous clear of every entry on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read ports with x0 forcing and same-cycle write bypass.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if (wr_en && (waddr == raddr1)) rdata1 = wdata;
    if (wr_en && (waddr == raddr2)) rdata2 = wdata;
    if (raddr1 == '0) rdata1 = '0;
    if (raddr2 == '0) rdata2 = '0;
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: register file writeback, PC redirect for resolved
// branch targets, retired-result counting and the end-of-program
// drain / cache flush / halt sequence.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   WB_RUN    | accepting results from the memory stage
//   WB_FLUSH  | program ended; flush_req held until flush_done pulse
//   WB_HALTED | flush complete; inputs ignored until rst
module writeback_stage
  import instruction_decode_types::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  double_word            mem_result_q,
  input  double_word            mem_result_q_plus_4,
  input  logic                  mem_result_valid_q,
  input  logic                  mem_is_branch_addr_q,
  input  logic                  mem_write_to_rd_q,
  input  logic [REG_ADDR_W-1:0] mem_rd_q,
  input  logic                  mem_should_end_q,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output double_word            rs1_data,
  output double_word            rs2_data,
  output logic                  redirect_valid,
  output double_word            redirect_pc,
  output double_word            redirect_pc_plus_4,
  output logic                  flush_req,
  input  logic                  flush_done,
  output logic [CNT_W-1:0]      retired_count,
  output logic                  halted
);

  wb_state_e        state_q, state_d;
  logic             accept;
  logic             rf_we;
  logic             redirect_valid_q;
  double_word       redirect_pc_q;
  double_word       redirect_pc_plus_4_q;
  logic [CNT_W-1:0] retired_count_q;

  assign accept = mem_result_valid_q && (state_q == WB_RUN);
  // Branch results carry a target, not a link value, so they never write rd.
  assign rf_we  = accept && mem_write_to_rd_q && !mem_is_branch_addr_q;

  reg_file_2r1w #(.NUM_REGS(NUM_REGS)) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (mem_rd_q),
    .wdata  (mem_result_q),
    .raddr1 (rs1_addr),
    .raddr2 (rs2_addr),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= WB_RUN;
    else     state_q <= state_d;
  end

  // Next-state and status outputs; flush_done is only honoured once in FLUSH.
  always_comb begin
    state_d   = state_q;
    flush_req = 1'b0;
    halted    = 1'b0;
    case (state_q)
      WB_RUN: begin
        if (accept && mem_should_end_q) state_d = WB_FLUSH;
      end
      WB_FLUSH: begin
        flush_req = 1'b1;
        if (flush_done) state_d = WB_HALTED;
      end
      WB_HALTED: begin
        halted = 1'b1;
      end
      default: state_d = WB_RUN;
    endcase
  end

  // One-cycle redirect pulse; target registers hold until the next branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q     <= 1'b0;
      redirect_pc_q        <= '0;
      redirect_pc_plus_4_q <= '0;
    end else begin
      redirect_valid_q <= accept && mem_is_branch_addr_q;
      if (accept && mem_is_branch_addr_q) begin
        redirect_pc_q        <= {mem_result_q[XLEN-1:1], 1'b0};
        redirect_pc_plus_4_q <= mem_result_q_plus_4;
      end
    end
  end

  // Retired-result counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)         retired_count_q <= '0;
    else if (accept) retired_count_q <= retired_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign redirect_valid     = redirect_valid_q;
  assign redirect_pc        = redirect_pc_q;
  assign redirect_pc_plus_4 = redirect_pc_plus_4_q;
  assign retired_count      = retired_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus a randomized run,
// all checked against a behavioural model of the stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] mem_result_q, mem_result_q_plus_4;
  logic        mem_result_valid_q, mem_is_branch_addr_q, mem_write_to_rd_q;
  logic [4:0]  mem_rd_q;
  logic        mem_should_end_q;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rs1_data, rs2_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc, redirect_pc_plus_4;
  logic        flush_req, flush_done;
  logic [63:0] retired_count;
  logic        halted;

  writeback_stage dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_result_q         (mem_result_q),
    .mem_result_q_plus_4  (mem_result_q_plus_4),
    .mem_result_valid_q   (mem_result_valid_q),
    .mem_is_branch_addr_q (mem_is_branch_addr_q),
    .mem_write_to_rd_q    (mem_write_to_rd_q),
    .mem_rd_q             (mem_rd_q),
    .mem_should_end_q     (mem_should_end_q),
    .rs1_addr             (rs1_addr),
    .rs2_addr             (rs2_addr),
    .rs1_data             (rs1_data),
    .rs2_data             (rs2_data),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .redirect_pc_plus_4   (redirect_pc_plus_4),
    .flush_req            (flush_req),
    .flush_done           (flush_done),
    .retired_count        (retired_count),
    .halted               (halted)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural contents and program status flags.
  logic [63:0] m_regs [32];
  logic [63:0] m_count;
  logic        m_rv;
  logic [63:0] m_pc, m_pc4;
  bit          m_ended, m_flushed;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_count = '0; m_rv = 1'b0; m_pc = '0; m_pc4 = '0;
    m_ended = 1'b0; m_flushed = 1'b0;
  endtask

  function automatic logic [63:0] exp_read(input logic [4:0] a);
    bit acc;
    acc = mem_result_valid_q && !m_ended;
    if (a == 0) return '0;
    if (acc && mem_write_to_rd_q && !mem_is_branch_addr_q && mem_rd_q == a) return mem_result_q;
    return m_regs[a];
  endfunction

  task automatic drive(input bit v, input bit br, input bit wr, input logic [4:0] rd,
                       input logic [63:0] d, input bit e, input logic [4:0] a1,
                       input logic [4:0] a2, input bit fd);
    mem_result_valid_q   = v;
    mem_is_branch_addr_q = br;
    mem_write_to_rd_q    = wr;
    mem_rd_q             = rd;
    mem_result_q         = d;
    mem_result_q_plus_4  = {d[63:1], 1'b0} + 64'd4;
    mem_should_end_q     = e;
    rs1_addr             = a1;
    rs2_addr             = a2;
    flush_done           = fd;
  endtask

  // One cycle: check combinational reads, clock, update model, check state.
  task automatic tick();
    bit acc;
    #1;
    if (!rst) begin
      check("rs1_data", rs1_data, exp_read(rs1_addr));
      check("rs2_data", rs2_data, exp_read(rs2_addr));
    end
    acc = mem_result_valid_q && !m_ended;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_ended && !m_flushed && flush_done) m_flushed = 1'b1;
      if (acc) begin
        m_count = m_count + 64'd1;
        if (mem_write_to_rd_q && !mem_is_branch_addr_q && mem_rd_q != 0)
          m_regs[mem_rd_q] = mem_result_q;
        if (mem_should_end_q) m_ended = 1'b1;
      end
      m_rv = acc && mem_is_branch_addr_q;
      if (m_rv) begin
        m_pc  = mem_result_q & ~64'd1;
        m_pc4 = mem_result_q_plus_4;
      end
    end
    #1;
    check("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_rv});
    check("redirect_pc", redirect_pc, m_pc);
    check("redirect_pc_plus_4", redirect_pc_plus_4, m_pc4);
    check("retired_count", retired_count, m_count);
    check("flush_req", {63'd0, flush_req}, {63'd0, (m_ended && !m_flushed)});
    check("halted", {63'd0, halted}, {63'd0, m_flushed});
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(0, 0, 0, 0, 64'd0, 0, a1, a2, 0);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle(0, 0);
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_count", retired_count, 64'd0);

    // Write x5, read it back next cycle.
    drive(1, 0, 1, 5, 64'hDEAD_BEEF, 0, 0, 0, 0); tick();
    idle(5, 0); tick();
    check("x5_readback", rs1_data, 64'hDEAD_BEEF);
    check("count_after_x5", retired_count, 64'd1);

    // Write to x0 is dropped but still counted.
    drive(1, 0, 1, 0, 64'h1234, 0, 0, 0, 0); tick();
    idle(0, 5); tick();

    // Same-cycle bypass on port 2.
    drive(1, 0, 1, 7, 64'hAA, 0, 5, 7, 0); tick();

    // Branch target with write_to_rd set: redirect, x1 untouched.
    drive(1, 1, 1, 1, 64'h8000_0003, 0, 1, 1, 0); tick();
    check("branch_pc", redirect_pc, 64'h8000_0002);
    check("branch_pc4", redirect_pc_plus_4, 64'h8000_0006);
    idle(1, 7); tick();
    check("x1_unchanged", rs1_data, 64'd0);

    // Randomized run while in RUN.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
            5'($urandom), {$urandom, $urandom}, 0, 5'($urandom), 5'($urandom),
            $urandom_range(0, 7) == 0);
      tick();
    end

    // Branch + end-of-program together; flush_done on entry cycle is ignored.
    drive(1, 1, 0, 3, 64'h4000_1001, 1, 0, 0, 1); tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 5'($urandom_range(1, 31)), {$urandom, $urandom}, 0,
            5'($urandom), 5'($urandom), 0);
      tick();
    end
    drive(1, 0, 1, 9, 64'h55, 0, 9, 9, 1); tick();
    for (int i = 0; i < 20; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 1, 5'($urandom), {$urandom, $urandom},
            $urandom_range(0, 1), 5'($urandom), 5'($urandom), $urandom_range(0, 1));
      tick();
    end

    // Reset from HALTED, then run into FLUSH and reset mid-handshake.
    rst = 1'b1; idle(0, 0); tick();
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      drive(1, 0, 1, 5'(i), {$urandom, $urandom}, 0, 5'(i), 5'(32 - i), 0);
      tick();
    end
    drive(1, 0, 1, 4, 64'hF00D, 1, 4, 4, 0); tick();
    idle(4, 0); tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(31 - i));
      tick();
    end
    drive(1, 0, 1, 6, 64'h77, 0, 6, 0, 0); tick();
    idle(6, 0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
